// File: rtl/proc_mem_responder.sv
// Memory-side responder: 256x15 array serving fetches, loads and stores, plus a byte-stream program loader.
// Optional store protection below PROT_LIMIT is compiled in with `define MEMRESP_WRPROT_EN.
module proc_mem_responder #(
    parameter logic [7:0] PROT_LIMIT = 8'h10
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic       MemWrite,
    input  logic [7:0] Adr,
    output logic [6:0] MemData1,
    inout  wire  [7:0] MemData2,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       cpu_hold,
    output logic       ld_done,
    output logic       wr_fault
);

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  la_q, la_d;
    logic [6:0]  hi_q, hi_d;
    logic        ld_ready_q, ld_ready_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        ld_done_q, ld_done_d;
    logic [14:0] mem_q [0:255];

    logic        mem_we_s;
    logic [7:0]  mem_wa_s;
    logic [14:0] mem_wd_s;
    logic [14:0] rd_word_s;
    logic [6:0]  md1_s;
    logic        bus_drive_s;
    logic        ld_data_unused_s;

    assign ld_data_unused_s = ld_data[7];
    assign rd_word_s        = mem_q[Adr];

    // State, load address, captured high byte and registered status outputs.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q    <= LOAD_HI;
            la_q       <= 8'h00;
            hi_q       <= 7'h00;
            ld_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            ld_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            la_q       <= la_d;
            hi_q       <= hi_d;
            ld_ready_q <= ld_ready_d;
            cpu_hold_q <= cpu_hold_d;
            ld_done_q  <= ld_done_d;
        end
    end

    // Loader sequencing; the word at 8'hFF forces completion so la never wraps.
    always_comb begin
        state_d = state_q;
        la_d    = la_q;
        hi_d    = hi_q;
        case (state_q)
            LOAD_HI: begin
                if (ld_valid) begin
                    hi_d    = ld_data[6:0];
                    state_d = LOAD_LO;
                end else begin
                    state_d = LOAD_HI;
                end
            end
            LOAD_LO: begin
                if (ld_valid) begin
                    if (ld_last || (la_q == 8'hFF)) begin
                        state_d = RUN;
                    end else begin
                        la_d    = la_q + 8'd1;
                        state_d = LOAD_HI;
                    end
                end else begin
                    state_d = LOAD_LO;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = LOAD_HI;
        endcase
    end

`ifdef MEMRESP_WRPROT_EN
    logic wr_fault_q, wr_fault_d;

    // Sticky protection fault, cleared only by reset.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            wr_fault_q <= 1'b0;
        end else begin
            wr_fault_q <= wr_fault_d;
        end
    end

    assign wr_fault = wr_fault_q;
`else
    assign wr_fault = 1'b0;
`endif

    // Bus drive, array write port and next values of the status outputs.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_wa_s    = Adr;
        mem_wd_s    = rd_word_s;
        md1_s       = 7'h00;
        bus_drive_s = 1'b0;
        ld_done_d   = 1'b0;
        ld_ready_d  = (state_d != RUN);
        cpu_hold_d  = (state_d != RUN);
`ifdef MEMRESP_WRPROT_EN
        wr_fault_d  = wr_fault_q;
`endif
        case (state_q)
            LOAD_HI: mem_we_s = 1'b0;
            LOAD_LO: begin
                if (ld_valid) begin
                    mem_we_s  = 1'b1;
                    mem_wa_s  = la_q;
                    mem_wd_s  = {hi_q, ld_data};
                    ld_done_d = (state_d == RUN);
                end else begin
                    mem_we_s  = 1'b0;
                end
            end
            RUN: begin
                md1_s = rd_word_s[14:8];
                if (MemWrite) begin
                    // Stores replace only the low byte; the bus is processor-driven.
                    mem_wd_s = {rd_word_s[14:8], MemData2};
`ifdef MEMRESP_WRPROT_EN
                    if (Adr < PROT_LIMIT) begin
                        mem_we_s   = 1'b0;
                        wr_fault_d = 1'b1;
                    end else begin
                        mem_we_s   = 1'b1;
                    end
`else
                    mem_we_s = 1'b1;
`endif
                end else begin
                    bus_drive_s = 1'b1;
                end
            end
            default: mem_we_s = 1'b0;
        endcase
    end

    // Storage array; intentionally not reset so contents survive reset.
    always_ff @(posedge ph1) begin
        if (mem_we_s) begin
            mem_q[mem_wa_s] <= mem_wd_s;
        end
    end

    assign MemData1 = md1_s;
    assign MemData2 = bus_drive_s ? rd_word_s[7:0] : {8{1'bz}};
    assign ld_ready = ld_ready_q;
    assign cpu_hold = cpu_hold_q;
    assign ld_done  = ld_done_q;

endmodule
